// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one 256-bit-line RAM port between the icache and
// dcache miss engines. Round-robin on ties, grant held while the owner keeps
// its enable high (write-back then fill), forced release on a stalled RAM.
module ram_port_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_write_en,
  input  logic [31:0]  i_addr,
  input  logic [255:0] i_data,
  output logic         i_ready,
  output logic [255:0] i_block,
  input  logic         d_en,
  input  logic         d_write_en,
  input  logic [31:0]  d_addr,
  input  logic [255:0] d_data,
  output logic         d_ready,
  output logic [255:0] d_block,
  output logic         ram_en,
  output logic         ram_write_en,
  output logic [31:0]  ram_addr,
  output logic [255:0] ram_data,
  input  logic         ram_ready,
  input  logic [255:0] ram_rdata,
  output logic         grant_i,
  output logic         grant_d,
  output logic         err,
  output logic [1:0]   stateOut
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    TURN  = 2'd3
  } state_t;

  // Counter value at which a grant with no ready is declared stalled.
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        last_d, last_d_nxt;   // 1: dcache won the most recent arbitration
  logic [15:0] cnt, cnt_nxt;
  logic        wd_fire;

  // State, round-robin history, watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      last_d <= 1'b1;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
      cnt    <= cnt_nxt;
      if (wd_fire) err <= 1'b1;
    end
  end

  // Next-state logic plus the port mux driven from the registered grant.
  always_comb begin
    state_nxt    = state;
    last_d_nxt   = last_d;
    cnt_nxt      = cnt;
    wd_fire      = 1'b0;
    ram_en       = 1'b0;
    ram_write_en = 1'b0;
    ram_addr     = '0;
    ram_data     = '0;
    i_ready      = 1'b0;
    d_ready      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        // On a tie the side that did not win last time goes first.
        if (i_en && (!d_en || last_d)) begin
          state_nxt  = GNT_I;
          last_d_nxt = 1'b0;
        end else if (d_en) begin
          state_nxt  = GNT_D;
          last_d_nxt = 1'b1;
        end
      end
      GNT_I: begin
        ram_en       = i_en;
        ram_write_en = i_write_en;
        ram_addr     = i_addr;
        ram_data     = i_data;
        i_ready      = ram_ready;
        wd_fire      = !ram_ready && (cnt == LIMIT);
        cnt_nxt      = ram_ready ? '0 : cnt + 16'd1;
        if (!i_en || wd_fire) state_nxt = TURN;
      end
      GNT_D: begin
        ram_en       = d_en;
        ram_write_en = d_write_en;
        ram_addr     = d_addr;
        ram_data     = d_data;
        d_ready      = ram_ready;
        wd_fire      = !ram_ready && (cnt == LIMIT);
        cnt_nxt      = ram_ready ? '0 : cnt + 16'd1;
        if (!d_en || wd_fire) state_nxt = TURN;
      end
      TURN: begin
        // One dead cycle so ram_en is low between two different masters.
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_i  = (state == GNT_I);
  assign grant_d  = (state == GNT_D);
  assign stateOut = state;
  assign i_block  = ram_rdata;
  assign d_block  = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios and random traffic, with a
// transaction-level owner/cool-down model feeding a scoreboard queue that a
// negedge monitor drains against the DUT outputs.
module tb_ram_port_arbiter;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_en, i_write_en, d_en, d_write_en, ram_ready;
  logic [31:0]  i_addr, d_addr;
  logic [255:0] i_data, d_data, ram_rdata;
  logic         i_ready, d_ready, ram_en, ram_write_en, grant_i, grant_d, err;
  logic [31:0]  ram_addr;
  logic [255:0] ram_data, i_block, d_block;
  logic [1:0]   stateOut;

  typedef struct packed {
    logic         i_en, i_we;
    logic [31:0]  i_addr;
    logic [255:0] i_data;
    logic         d_en, d_we;
    logic [31:0]  d_addr;
    logic [255:0] d_data;
    logic         ram_ready;
    logic [255:0] rdata;
  } stim_t;

  typedef struct packed {
    logic         ram_en, ram_we, gi, gd, ir, dr, err;
    logic [1:0]   st;
    logic [31:0]  addr;
    logic [255:0] data, blk;
  } exp_t;

  exp_t  sbq[$];
  int    tests = 0;
  int    fails = 0;
  stim_t s, cur;

  // Reference model: who owns the port (0 none, 1 icache, 2 dcache),
  // whether the dead cycle is pending, who won last, cycles since progress.
  int m_owner;
  bit m_turn, m_last_d, m_err;
  int m_wait;

  ram_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_en(i_en), .i_write_en(i_write_en), .i_addr(i_addr), .i_data(i_data),
    .i_ready(i_ready), .i_block(i_block),
    .d_en(d_en), .d_write_en(d_write_en), .d_addr(d_addr), .d_data(d_data),
    .d_ready(d_ready), .d_block(d_block),
    .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_ready(ram_ready), .ram_rdata(ram_rdata),
    .grant_i(grant_i), .grant_d(grant_d), .err(err), .stateOut(stateOut)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input stim_t c);
    i_en = c.i_en; i_write_en = c.i_we; i_addr = c.i_addr; i_data = c.i_data;
    d_en = c.d_en; d_write_en = c.d_we; d_addr = c.d_addr; d_data = c.d_data;
    ram_ready = c.ram_ready; ram_rdata = c.rdata;
  endtask

  function automatic void model_reset();
    m_owner = 0; m_turn = 0; m_last_d = 1; m_err = 0; m_wait = 0;
  endfunction

  // Advance the model across one clock edge using the inputs of the cycle just ended.
  function automatic void model_update(input stim_t c);
    bit holding, starved;
    if (m_owner != 0) begin
      holding = (m_owner == 1) ? c.i_en : c.d_en;
      starved = !c.ram_ready && (m_wait == TO - 1);
      if (starved) m_err = 1;
      if (!holding || starved) begin
        m_owner = 0;
        m_turn  = 1;
      end else begin
        m_wait = c.ram_ready ? 0 : m_wait + 1;
      end
    end else if (m_turn) begin
      m_turn = 0;
    end else begin
      int win;
      win = 0;
      if (c.i_en && c.d_en) win = m_last_d ? 1 : 2;
      else if (c.i_en)      win = 1;
      else if (c.d_en)      win = 2;
      if (win != 0) begin
        m_owner  = win;
        m_last_d = (win == 2);
        m_wait   = 0;
      end
    end
  endfunction

  function automatic exp_t expect_out(input stim_t c);
    exp_t e;
    e     = '0;
    e.blk = c.rdata;
    e.err = m_err;
    if (m_owner == 1) begin
      e.ram_en = c.i_en; e.ram_we = c.i_we; e.addr = c.i_addr; e.data = c.i_data;
      e.ir = c.ram_ready; e.gi = 1; e.st = 2'd1;
    end else if (m_owner == 2) begin
      e.ram_en = c.d_en; e.ram_we = c.d_we; e.addr = c.d_addr; e.data = c.d_data;
      e.dr = c.ram_ready; e.gd = 1; e.st = 2'd2;
    end else if (m_turn) begin
      e.st = 2'd3;
    end
    return e;
  endfunction

  // One clock cycle: update model at the edge, drive s, queue the expected outputs.
  task automatic step(input bit rel = 1'b0);
    @(posedge clk);
    if (rst) model_update(cur);
    #1;
    if (rel) rst = 1'b1;
    cur = s;
    drive(cur);
    sbq.push_back(expect_out(cur));
    #1;
  endtask

  // Like step, but pulls reset low part-way through the cycle.
  task automatic mid_reset();
    @(posedge clk);
    if (rst) model_update(cur);
    #1;
    cur = s;
    drive(cur);
    #2;
    rst = 1'b0;
    model_reset();
    sbq.push_back(expect_out(cur));
    #1;
  endtask

  task automatic side(inout logic en, inout int hold, inout int gap);
    if (en) begin
      if (hold == 0) begin
        en  = 1'b0;
        gap = $urandom_range(0, 4);
      end else hold--;
    end else if (gap == 0) begin
      en   = 1'b1;
      hold = $urandom_range(1, 12);
    end else gap--;
  endtask

  // Scoreboard monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb_ctrl", {ram_en, ram_write_en, grant_i, grant_d, i_ready, d_ready, err, stateOut},
          {e.ram_en, e.ram_we, e.gi, e.gd, e.ir, e.dr, e.err, e.st});
      chk("sb_ram_addr", ram_addr, e.addr);
      chk("sb_ram_data", ram_data, e.data);
      chk("sb_i_block", i_block, e.blk);
      chk("sb_d_block", d_block, e.blk);
    end
  end

  initial begin
    int ih, ig, dh, dg;
    rst = 1'b1;
    s = '0; cur = '0;
    drive(cur);
    model_reset();
    #2 rst = 1'b0;

    // Requests and a ready pulse held during reset must not reach the port.
    s.i_en = 1; s.d_en = 1; s.i_addr = 32'hDEAD_BEEF; s.i_data = rand256();
    s.ram_ready = 1; s.rdata = rand256();
    step(); step();
    chk("rst_grant", {grant_i, grant_d}, 0);
    chk("rst_err", err, 0);
    chk("rst_state", stateOut, 0);
    chk("rst_port", {ram_en, ram_write_en, i_ready, d_ready}, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_block", i_block, s.rdata);
    s = '0;
    step(1'b1);

    // Three simultaneous requests in a row: I, D, I.
    for (int t = 0; t < 3; t++) begin
      s.i_en = 1; s.d_en = 1; s.i_we = 0; s.d_we = 0;
      s.i_addr = 32'h100 + t; s.d_addr = 32'h200 + t;
      step();
      step();
      chk("tie_gi", grant_i, (t != 1));
      chk("tie_gd", grant_d, (t == 1));
      chk("tie_en", ram_en, 1);
      s.ram_ready = 1; s.rdata = rand256();
      step();
      chk("tie_rdy", {i_ready, d_ready}, (t == 1) ? 2'b01 : 2'b10);
      s.ram_ready = 0; s.i_en = 0; s.d_en = 0;
      step();
      step();
      chk("tie_turn", stateOut, 3);
      step();
      chk("tie_gap_en", ram_en, 0);
    end

    // Basic icache read.
    s = '0; s.i_en = 1; s.i_addr = 32'h0000_1000;
    step(); step();
    chk("rd_grant_i", grant_i, 1);
    chk("rd_addr", ram_addr, 32'h0000_1000);
    chk("rd_we", ram_write_en, 0);
    s.ram_ready = 1; s.rdata = {32{8'hA5}};
    step();
    chk("rd_i_ready", i_ready, 1);
    chk("rd_i_block", i_block, {32{8'hA5}});
    chk("rd_d_ready", d_ready, 0);
    s.ram_ready = 0; s.i_en = 0;
    step(); step(); step();

    // dcache write-back then fill under one grant while icache waits.
    s.d_en = 1; s.d_we = 1; s.d_addr = 32'h0000_2000; s.d_data = rand256();
    step();
    s.i_en = 1; s.i_addr = 32'h0000_3000;
    step();
    chk("wb_grant_d", grant_d, 1);
    chk("wb_we", ram_write_en, 1);
    chk("wb_addr", ram_addr, 32'h0000_2000);
    chk("wb_data", ram_data, s.d_data);
    s.ram_ready = 1;
    step();
    chk("wb_rdy", {i_ready, d_ready}, 2'b01);
    s.ram_ready = 0; s.d_we = 0;
    step();
    chk("fill_grant_d", grant_d, 1);
    chk("fill_we", ram_write_en, 0);
    step();
    s.ram_ready = 1; s.rdata = rand256();
    step();
    chk("fill_rdy", {grant_d, d_ready, i_ready}, 3'b110);
    s.ram_ready = 0; s.d_en = 0;
    step();
    step();
    chk("rel_turn", stateOut, 3);
    step();
    chk("rel_idle_gi", grant_i, 0);
    step();
    chk("rel_gi_m3", grant_i, 1);

    // ram_ready outside a grant is ignored.
    s.i_en = 0;
    step();
    s.ram_ready = 1;
    step();
    chk("stray_turn_rdy", {i_ready, d_ready}, 0);
    chk("stray_turn_st", stateOut, 3);
    step();
    chk("stray_idle_rdy", {i_ready, d_ready}, 0);
    chk("stray_idle_st", stateOut, 0);
    s.ram_ready = 0;
    step();
    chk("stray_after_st", stateOut, 0);

    // Watchdog: dcache granted, RAM never answers.
    s.d_en = 1; s.d_we = 0; s.d_addr = 32'h0000_4000;
    step();
    step();
    chk("wd_grant", grant_d, 1);
    chk("wd_err0", err, 0);
    repeat (7) step();
    chk("wd_pre_err", err, 0);
    chk("wd_pre_st", stateOut, 2);
    s.d_en = 0;
    step();
    chk("wd_err", err, 1);
    chk("wd_turn", stateOut, 3);
    step();
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 1) begin
        s.i_en = 1; s.i_we = 1'($urandom_range(0, 1)); s.i_addr = $urandom; s.i_data = rand256();
      end else begin
        s.d_en = 1; s.d_we = 1'($urandom_range(0, 1)); s.d_addr = $urandom; s.d_data = rand256();
      end
      step();
      s.ram_ready = 1; s.rdata = rand256();
      step();
      s.ram_ready = 0; s.i_en = 0; s.d_en = 0;
      step(); step(); step();
      chk("wd_sticky", err, 1);
    end

    // Asynchronous reset in the middle of a grant.
    s.i_en = 1; s.i_addr = 32'h0000_5000;
    step(); step();
    chk("mr_pre_grant", grant_i, 1);
    s.d_en = 1;
    mid_reset();
    chk("mr_ram_en", ram_en, 0);
    chk("mr_grant", {grant_i, grant_d}, 0);
    chk("mr_state", stateOut, 0);
    chk("mr_err", err, 0);
    step();
    step(1'b1);
    step();
    chk("mr_first_tie", {grant_i, grant_d}, 2'b10);
    s.i_en = 0; s.d_en = 0;
    step(); step(); step();

    // Random traffic against the model.
    ih = 0; ig = 0; dh = 0; dg = 0;
    for (int c = 0; c < 1500; c++) begin
      side(s.i_en, ih, ig);
      side(s.d_en, dh, dg);
      if ($urandom_range(0, 4) == 0) s.i_we = ~s.i_we;
      if ($urandom_range(0, 4) == 0) s.d_we = ~s.d_we;
      if ($urandom_range(0, 3) == 0) begin s.i_addr = $urandom; s.i_data = rand256(); end
      if ($urandom_range(0, 3) == 0) begin s.d_addr = $urandom; s.d_data = rand256(); end
      s.ram_ready = ($urandom_range(0, 99) < 35);
      s.rdata = rand256();
      step();
    end

    s = '0;
    repeat (3) step();
    @(negedge clk);
    #1;
    chk("sb_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single 256-bit-line RAM port between the instruction-cache and data-cache miss engines. Each cache presents the same request interface that `cache_manage` drives toward RAM: enable, write, address and line. The arbiter grants one cache at a time and holds the grant across a write-back-then-fill sequence. It routes `ram_ready` only to the granted side and flags a stalled RAM with a watchdog. It sits between the two cache tops and the RAM model or memory controller.

## Interface
- `TIMEOUT`, 1024: cycles a grant may wait for `ram_ready` before the watchdog fires. Legal range is 2..65535.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-low reset. Asserts immediately; releases synchronously to `clk` at system level.
- `i_en`, `i_write_en` in 1 each: icache request and direction.
- `i_addr` in 32, `i_data` in 256: icache line address and write-back line.
- `i_ready` out 1: `ram_ready` forwarded to the icache while it is granted.
- `d_en`, `d_write_en` in 1 each; `d_addr` in 32; `d_data` in 256; `d_ready` out 1: same roles for the dcache.
- `i_block`, `d_block` out 256: read line. Both are a straight fan-out of `ram_rdata`.
- `ram_en`, `ram_write_en` out 1 each; `ram_addr` out 32; `ram_data` out 256: the shared RAM port.
- `ram_ready` in 1: one-cycle pulse per completed RAM transaction.
- `ram_rdata` in 256: read line from RAM, valid with `ram_ready`.
- `grant_i`, `grant_d` out 1 each: registered, one-hot-or-zero.
- `err` out 1: sticky watchdog flag.
- `stateOut` out 2: debug view of the FSM state.

## Operation
- FSM states: IDLE=0, GNT_I=1, GNT_D=2, TURN=3. `stateOut` shows the state directly.
- IDLE, only `i_en` high: go to GNT_I. Only `d_en` high: go to GNT_D.
- IDLE, both high: grant the side that did not win last. `last` register resets to D, so the first tie goes to I.
- IDLE, neither high: stay in IDLE.
- On entering GNT_x, set `last` to x.
- GNT_x holds while `x_en` is high, across any number of `ram_ready` pulses.
  - This covers a write-back (write=1) followed by a fill (write=0) with `x_en` held continuously.
  - `x_write_en` may change between pulses; the RAM sees the new direction immediately.
- GNT_x with `x_en` low at a posedge: go to TURN.
- TURN always goes to IDLE. This guarantees at least one `ram_en`-low cycle between masters.
- Port mux while in GNT_x:
  - `ram_en` = `x_en`, `ram_write_en` = `x_write_en`, `ram_addr` = `x_addr`, `ram_data` = `x_data`.
  - `x_ready` = `ram_ready`; the other side's ready = 0.
- In IDLE and TURN: all `ram_*` outputs are 0 and both readies are 0.
- A `ram_ready` pulse arriving outside a grant is ignored.
- Watchdog:
  - 16-bit counter, cleared on grant entry and on every `ram_ready` pulse while granted; increments on every other granted cycle.
  - When the counter reaches TIMEOUT-1 with no `ram_ready` that cycle: set `err` and force TURN.
  - `err` clears only on reset.
  - If the starved requester still holds `x_en` after the forced release, it re-arbitrates normally. Round-robin lets the other side in first if it is also requesting.
- The read line is not buffered: caches sample `x_block` in the same cycle as `x_ready`.

## Timing
- Reset values:
  - State IDLE, `last`=D, counter 0.
  - `grant_i`=0, `grant_d`=0, `err`=0, `stateOut`=0.
  - `ram_en`, `ram_write_en`, `ram_addr`, `ram_data`, `i_ready`, `d_ready` all 0.
  - `i_block`/`d_block` follow `ram_rdata`.
- Arbitration latency: a request sampled at posedge N gives a grant and `ram_en` high from N+1. That is one cycle from `x_en` rising to `ram_en` rising.
- Ready path is combinational, zero cycles (`ram_ready` to `x_ready`). Port mux is combinational from the registered grant.
- Release: `x_en` low at posedge M gives TURN during M+1 and IDLE during M+2. The earliest next grant is visible at M+3.
- Simultaneous `x_en` fall and `ram_ready`: the pulse is forwarded that cycle, then release proceeds as normal.
- Reset asserted mid-grant: `ram_en` drops asynchronously and the grant and counter clear. A transaction already in flight in RAM is abandoned.
- Watchdog with TIMEOUT=T: if the grant starts at cycle G and no ready arrives, `err` rises and the state is TURN at cycle G+T.

## Test plan
- Reset, then `i_en`=1, `i_write_en`=0, `i_addr`=0x0000_1000 → `grant_i`=1 and `ram_addr`=0x0000_1000 from the next cycle. `ram_ready` pulse with `ram_rdata`=0xA5…A5 → `i_ready`=1, `i_block`=0xA5…A5, `d_ready`=0.
- `i_en` and `d_en` rise in the same cycle, 3 times back-to-back with release in between → grant order I, D, I. The cycle after each TURN shows `ram_en`=0.
- dcache holds `d_en`: write-back with `d_write_en`=1 and `d_addr`=0x0000_2000, ready pulse, then `d_write_en`=0. Meanwhile `i_en`=1 throughout → grant stays D across both pulses; icache is granted exactly 3 cycles after `d_en` falls.
- TIMEOUT=8, `d_en`=1, no `ram_ready` → `err`=1 and `stateOut`=3 eight cycles after the grant. `err` stays 1 through 20 further normal transactions.
- `ram_ready` pulsed during IDLE and during TURN → `i_ready`=`d_ready`=0 and no state change.
- `rst` driven low mid-grant between clock edges → `ram_en`, `grant_*` and `stateOut` go to 0 before the next posedge. After release, the first tie is granted to I.
